// File: rtl/hdmi_timing_pkg.sv
// Shared timing constants, HVE bit positions and bar colours
// for the HDMI raster/test-pattern source.
`timescale 1ns/1ps
package hdmi_timing_pkg;

    // Default 640x480@60 raster
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int CNT_W = 13;

    // Bit positions inside the packed {hsync, vsync, de} bus
    localparam int HVE_HSYNC = 2;
    localparam int HVE_VSYNC = 1;
    localparam int HVE_DE    = 0;

    localparam logic [23:0] COLOR_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] COLOR_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] COLOR_CYAN    = 24'h00FFFF;
    localparam logic [23:0] COLOR_GREEN   = 24'h00FF00;
    localparam logic [23:0] COLOR_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] COLOR_RED     = 24'hFF0000;
    localparam logic [23:0] COLOR_BLUE    = 24'h0000FF;
    localparam logic [23:0] COLOR_BLACK   = 24'h000000;

    // Map a bar index (left to right) to its colour
    function automatic logic [23:0] bar_color(input logic [2:0] idx);
        logic [23:0] c;
        c = COLOR_BLACK;
        unique case (idx)
            3'd0: c = COLOR_WHITE;
            3'd1: c = COLOR_YELLOW;
            3'd2: c = COLOR_CYAN;
            3'd3: c = COLOR_GREEN;
            3'd4: c = COLOR_MAGENTA;
            3'd5: c = COLOR_RED;
            3'd6: c = COLOR_BLUE;
            3'd7: c = COLOR_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/hdmi_timing_gen_color_bar_gen.sv
// 8-bar colour pattern: bar counter/index track the current
// pixel, colour is registered and blanked outside active video.
`timescale 1ns/1ps
module color_bar_gen
    import hdmi_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE
) (
    input  logic        hdmi_clk,
    input  logic        reset,
    input  logic        line_end,
    input  logic        de,
    output logic [23:0] o_color
);

    localparam int BAR_W = H_ACTIVE / 8;
    localparam int BW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

    logic [BW-1:0] bar_cnt;
    logic [2:0]    bar_idx;

    // Step through bars without a divider; restart at each line start
    always_ff @(posedge hdmi_clk or posedge reset) begin
        if (reset) begin
            bar_cnt <= '0;
            bar_idx <= '0;
            o_color <= '0;
        end else begin
            o_color <= de ? bar_color(bar_idx) : COLOR_BLACK;
            if (line_end) begin
                bar_cnt <= '0;
                bar_idx <= '0;
            end else if (bar_cnt == BAR_LAST) begin
                bar_cnt <= '0;
                bar_idx <= bar_idx + 3'd1;
            end else begin
                bar_cnt <= bar_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/hdmi_timing_gen.sv
// Raster timing generator: pixel position, sync/DE bus,
// frame pulse/counter and colour bars, all aligned registers.
`timescale 1ns/1ps
module hdmi_timing_gen
    import hdmi_timing_pkg::*;
#(
    parameter int   H_ACTIVE  = DEF_H_ACTIVE,
    parameter int   H_FP      = DEF_H_FP,
    parameter int   H_SYNC    = DEF_H_SYNC,
    parameter int   H_BP      = DEF_H_BP,
    parameter int   V_ACTIVE  = DEF_V_ACTIVE,
    parameter int   V_FP      = DEF_V_FP,
    parameter int   V_SYNC    = DEF_V_SYNC,
    parameter int   V_BP      = DEF_V_BP,
    parameter logic HSYNC_POL = 1'b0,
    parameter logic VSYNC_POL = 1'b0
) (
    input  logic             hdmi_clk,
    input  logic             reset,
    output logic [2:0]       o_hve,
    output logic [23:0]      o_color,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             o_frame_start,
    output logic [7:0]       o_frame
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT   = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT   = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG  = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG  = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             h_end;
    logic             v_end;
    logic             de;
    logic             hs_on;
    logic             vs_on;
    logic             at_origin;

    // Decode the pixel currently held in the counters
    always_comb begin
        h_end     = (h_cnt == H_LAST);
        v_end     = (v_cnt == V_LAST);
        de        = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        hs_on     = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
        vs_on     = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
        at_origin = (h_cnt == '0) && (v_cnt == '0);
    end

    // Raster counters: one pixel per clock, line then frame wrap
    always_ff @(posedge hdmi_clk or posedge reset) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_end) begin
            h_cnt <= '0;
            v_cnt <= v_end ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    // Register position, syncs and frame info for the same pixel
    always_ff @(posedge hdmi_clk or posedge reset) begin
        if (reset) begin
            x                <= '0;
            y                <= '0;
            o_hve[HVE_HSYNC] <= ~HSYNC_POL;
            o_hve[HVE_VSYNC] <= ~VSYNC_POL;
            o_hve[HVE_DE]    <= 1'b0;
            o_frame_start    <= 1'b0;
            o_frame          <= '0;
        end else begin
            x                <= h_cnt;
            y                <= v_cnt;
            o_hve[HVE_HSYNC] <= hs_on ? HSYNC_POL : ~HSYNC_POL;
            o_hve[HVE_VSYNC] <= vs_on ? VSYNC_POL : ~VSYNC_POL;
            o_hve[HVE_DE]    <= de;
            o_frame_start    <= at_origin;
            if (at_origin) begin
                o_frame <= o_frame + 8'd1;
            end
        end
    end

    color_bar_gen #(
        .H_ACTIVE (H_ACTIVE)
    ) u_color_bar_gen (
        .hdmi_clk (hdmi_clk),
        .reset    (reset),
        .line_end (h_end),
        .de       (de),
        .o_color  (o_color)
    );

endmodule

// File: tb/tb_hdmi_timing_gen.sv
// Self-checking bench: every output compared each cycle against
// a raster model computed from the pixel index since reset.
`timescale 1ns/1ps
module tb_hdmi_timing_gen;

    localparam int HA = 16;
    localparam int HF = 2;
    localparam int HS = 3;
    localparam int HB = 3;
    localparam int VA = 4;
    localparam int VF = 1;
    localparam int VS = 1;
    localparam int VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;
    localparam logic HPOL = 1'b0;
    localparam logic VPOL = 1'b0;

    logic        hdmi_clk;
    logic        reset;
    logic [2:0]  o_hve;
    logic [23:0] o_color;
    logic [12:0] x;
    logic [12:0] y;
    logic        o_frame_start;
    logic [7:0]  o_frame;

    int unsigned n_chk;
    int unsigned n_pass;
    int unsigned n_edge;
    bit          chk_on;

    logic [23:0] bars [8];

    hdmi_timing_gen #(
        .H_ACTIVE  (HA),
        .H_FP      (HF),
        .H_SYNC    (HS),
        .H_BP      (HB),
        .V_ACTIVE  (VA),
        .V_FP      (VF),
        .V_SYNC    (VS),
        .V_BP      (VB),
        .HSYNC_POL (HPOL),
        .VSYNC_POL (VPOL)
    ) dut (
        .hdmi_clk      (hdmi_clk),
        .reset         (reset),
        .o_hve         (o_hve),
        .o_color       (o_color),
        .x             (x),
        .y             (y),
        .o_frame_start (o_frame_start),
        .o_frame       (o_frame)
    );

    initial hdmi_clk = 1'b0;
    always #5 hdmi_clk = ~hdmi_clk;

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Expected {x,y,hve,color,fs,frame} after n edges since reset
    function automatic logic [61:0] model(input int unsigned n);
        int unsigned p, h, v;
        logic de, hs, vs, fs;
        logic [23:0] col;
        logic [7:0] fr;
        if (n == 0)
            return {13'd0, 13'd0, ~HPOL, ~VPOL, 1'b0, 24'd0, 1'b0, 8'd0};
        p   = n - 1;
        h   = p % HT;
        v   = (p / HT) % VT;
        de  = (h < HA) && (v < VA);
        hs  = (h >= HA + HF && h < HA + HF + HS) ? HPOL : ~HPOL;
        vs  = (v >= VA + VF && v < VA + VF + VS) ? VPOL : ~VPOL;
        col = de ? bars[h / (HA / 8)] : 24'd0;
        fs  = (p % FT) == 0;
        fr  = 8'((p / FT + 1) % 256);
        return {13'(h), 13'(v), hs, vs, de, col, fs, fr};
    endfunction

    function automatic logic [61:0] observed();
        return {x, y, o_hve, o_color, o_frame_start, o_frame};
    endfunction

    always @(posedge hdmi_clk or posedge reset) begin
        if (reset) n_edge <= 0;
        else       n_edge <= n_edge + 1;
    end

    always @(negedge hdmi_clk) begin
        if (chk_on) chk("pixel", 64'(observed()), 64'(model(n_edge)));
    end

    initial begin
        int unsigned last_fs;
        int unsigned de_cnt;
        bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        n_chk  = 0;
        n_pass = 0;
        chk_on = 1'b0;
        reset  = 1'b1;
        #1;
        chk("rst_async", 64'(observed()), 64'(model(0)));
        chk_on = 1'b1;
        repeat (3) @(negedge hdmi_clk);
        chk("rst_hve", 64'(o_hve), 64'(3'b110));
        reset   = 1'b0;
        last_fs = 0;
        de_cnt  = 0;
        for (int i = 1; i <= 256 * FT; i++) begin
            @(negedge hdmi_clk);
            if (i == 1)
                chk("first_pix",
                    64'({x, y, o_hve, o_color, o_frame_start, o_frame}),
                    64'({13'd0, 13'd0, 3'b111, 24'hFFFFFF, 1'b1, 8'd1}));
            if (o_hve[0]) de_cnt++;
            if (o_frame_start) begin
                if (last_fs != 0) chk("fs_gap", 64'(i - last_fs), 64'(FT));
                last_fs = i;
            end
            if (i % FT == 0) begin
                chk("de_frame", 64'(de_cnt), 64'(HA * VA));
                de_cnt = 0;
            end
            if (i == 255 * FT + 1)
                chk("frame_wrap", 64'(o_frame), 64'(0));
        end
        for (int k = 0; k < 6; k++) begin
            repeat ($urandom_range(1, 3 * FT)) @(negedge hdmi_clk);
            @(posedge hdmi_clk);
            #($urandom_range(1, 3));
            reset = 1'b1;
            #1;
            chk("rst_mid", 64'(observed()), 64'(model(0)));
            repeat ($urandom_range(1, 3)) @(negedge hdmi_clk);
            reset = 1'b0;
            @(negedge hdmi_clk);
            chk("restart_frame", 64'(o_frame), 64'(1));
        end
        repeat (FT + 5) @(negedge hdmi_clk);
        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
